// File: rtl/poly_encode_stream.sv
// rtl/poly_encode_stream.sv - reads NUM_POLYS bank polynomials and streams them out as ByteEncode12 bytes
// Optional: POLY_ENC_REDUCE_EN folds each captured coefficient into [0,3328] before packing.
module poly_encode_stream #(
    parameter int NUM_POLYS = 3,
    parameter int N         = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  slot_base,
    input  logic [4:0]  slot_stride,
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [4:0]  rd_slot,
    output logic [7:0]  rd_addr,
    input  logic [11:0] rd_data,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    input  logic        byte_ready
);

    localparam logic [6:0] PAIR_LAST = 7'(N / 2 - 1);
    localparam logic [2:0] POLY_LAST = 3'(NUM_POLYS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CAP,
        EMIT,
        DONE
    } state_t;

    state_t      state_q;
    logic        busy_q;
    logic        done_q;
    logic        rd_en_q;
    logic [4:0]  rd_slot_q;
    logic [7:0]  rd_addr_q;
    logic [4:0]  stride_q;
    logic [6:0]  pair_q;
    logic [2:0]  poly_q;
    logic [1:0]  j_q;
    logic [11:0] a_q;
    logic [11:0] b_q;
    logic        byte_valid_q;
    logic [7:0]  byte_data_q;
    logic [11:0] coef_d;

`ifdef POLY_ENC_REDUCE_EN
    assign coef_d = (rd_data >= 12'd3329) ? (rd_data - 12'd3329) : rd_data;
`else
    assign coef_d = rd_data;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_en      = rd_en_q;
    assign rd_slot    = rd_slot_q;
    assign rd_addr    = rd_addr_q;
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_slot_q    <= 5'd0;
            rd_addr_q    <= 8'd0;
            stride_q     <= 5'd0;
            pair_q       <= 7'd0;
            poly_q       <= 3'd0;
            j_q          <= 2'd0;
            a_q          <= 12'd0;
            b_q          <= 12'd0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RD_A;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_slot_q <= slot_base;
                        stride_q  <= slot_stride;
                        rd_addr_q <= 8'd0;
                        pair_q    <= 7'd0;
                        poly_q    <= 3'd0;
                    end
                end
                RD_A: begin
                    state_q   <= RD_B;
                    rd_addr_q <= {pair_q, 1'b1};
                end
                // rd_data now carries the even coefficient requested in RD_A
                RD_B: begin
                    state_q <= CAP;
                    rd_en_q <= 1'b0;
                    a_q     <= coef_d;
                end
                CAP: begin
                    state_q      <= EMIT;
                    b_q          <= coef_d;
                    byte_data_q  <= a_q[7:0];
                    byte_valid_q <= 1'b1;
                    j_q          <= 2'd0;
                end
                EMIT: begin
                    if (byte_ready) begin
                        case (j_q)
                            2'd0: begin
                                byte_data_q <= {b_q[3:0], a_q[11:8]};
                                j_q         <= 2'd1;
                            end
                            2'd1: begin
                                byte_data_q <= b_q[11:4];
                                j_q         <= 2'd2;
                            end
                            default: begin
                                byte_valid_q <= 1'b0;
                                j_q          <= 2'd0;
                                if (pair_q != PAIR_LAST) begin
                                    pair_q    <= pair_q + 7'd1;
                                    rd_addr_q <= {pair_q + 7'd1, 1'b0};
                                    rd_en_q   <= 1'b1;
                                    state_q   <= RD_A;
                                end else if (poly_q != POLY_LAST) begin
                                    poly_q    <= poly_q + 3'd1;
                                    pair_q    <= 7'd0;
                                    rd_addr_q <= 8'd0;
                                    rd_slot_q <= rd_slot_q + stride_q;
                                    rd_en_q   <= 1'b1;
                                    state_q   <= RD_A;
                                end else begin
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                    state_q <= DONE;
                                end
                            end
                        endcase
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_encode_stream.sv
// tb/tb_poly_encode_stream.sv - scoreboard bench for poly_encode_stream
module tb_poly_encode_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  slot_base;
    logic [4:0]  slot_stride;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [4:0]  rd_slot;
    logic [7:0]  rd_addr;
    logic [11:0] rd_data = 12'd0;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;

    always #5 clk = ~clk;

    poly_encode_stream dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .slot_base   (slot_base),
        .slot_stride (slot_stride),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_slot     (rd_slot),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready)
    );

    logic [11:0] bank [0:31][0:255];

    always @(posedge clk) begin
        if (rd_en) rd_data <= bank[rd_slot][rd_addr];
    end

    logic [7:0] sb[$];
    logic [4:0] slot_q[$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int hs_count = 0;
    int done_count = 0;
    int done_cyc = -1;
    int last_hs_cyc = -1;
    int first_valid_cyc = -1;
    bit rand_ready = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] red(input logic [11:0] c);
`ifdef POLY_ENC_REDUCE_EN
        return (c >= 12'd3329) ? c - 12'd3329 : c;
`else
        return c;
`endif
    endfunction

    task automatic push3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        sb.push_back(b0);
        sb.push_back(b1);
        sb.push_back(b2);
    endtask

    task automatic push_model(input logic [4:0] base, input logic [4:0] stride, input int skip);
        for (int p = 0; p < 3; p++) begin
            logic [4:0] s;
            s = base + 5'(p) * stride;
            for (int k = (p == 0) ? skip : 0; k < 128; k++) begin
                logic [11:0] a, b;
                a = red(bank[s][2*k]);
                b = red(bank[s][2*k+1]);
                push3(a[7:0], {b[3:0], a[11:8]}, b[11:4]);
            end
        end
    endtask

    task automatic fill_bank();
        for (int s = 0; s < 32; s++)
            for (int a = 0; a < 256; a++) begin
                logic [4:0] s5;
                s5 = 5'(s);
                bank[s][a] = {s5[3:0], 8'(a)};
            end
    endtask

    initial begin
        byte_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            byte_ready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end

    // Scoreboard monitor: samples on the falling edge, away from DUT updates
    always @(negedge clk) begin
        if (prev_stall && rst_n) begin
            check("stall_valid_hold", {31'd0, byte_valid}, 32'd1);
            check("stall_data_hold", {24'd0, byte_data}, {24'd0, prev_data});
        end
        prev_stall = rst_n && byte_valid && !byte_ready;
        prev_data  = byte_data;
        if (rd_en && rd_addr == 8'd0) slot_q.push_back(rd_slot);
        if (byte_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (byte_valid && byte_ready && rst_n) begin
            if (sb.size() == 0) begin
                check("byte_unexpected", {24'd0, byte_data}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                check("byte_data", {24'd0, byte_data}, {24'd0, e});
            end
            hs_count++;
            last_hs_cyc = cyc;
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic run(input logic [4:0] base, input logic [4:0] stride, input int abort_at,
                       input bit start_in_done, input bit pulse_busy);
        int s_cyc, t, d0;
        hs_count = 0;
        first_valid_cyc = -1;
        slot_q.delete();
        d0 = done_count;
        @(posedge clk);
        #1;
        slot_base   = base;
        slot_stride = stride;
        start       = 1'b1;
        s_cyc       = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        t = 0;
        forever begin
            @(posedge clk);
            #1;
            start = 1'b0;
            t++;
            if (done || hs_count >= abort_at || t > 20000) break;
            if (pulse_busy && (t % 97 == 0)) begin
                slot_base   = base + 5'd7;
                slot_stride = stride + 5'd1;
                start       = 1'b1;
            end
        end
        slot_base   = base;
        slot_stride = stride;
        if (t > 20000) begin
            check("run_timeout", 32'd0, 32'd1);
        end else if (hs_count >= abort_at) begin
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            check("abort_valid", {31'd0, byte_valid}, 32'd0);
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_done", {31'd0, done}, 32'd0);
            repeat (5) @(posedge clk);
            #1;
            check("abort_no_done", done_count, d0);
            sb.delete();
        end else begin
            if (start_in_done) start = 1'b1;
            @(negedge clk);
            #1;
            check("latency", first_valid_cyc - s_cyc, 32'd4);
            check("byte_count", hs_count, 32'd1152);
            check("sb_drained", sb.size(), 32'd0);
            check("done_after_last", done_cyc - last_hs_cyc, 32'd1);
            check("done_once", done_count - d0, 32'd1);
            check("busy_in_done", {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1;
            start = 1'b0;
            @(posedge clk);
            #1;
            check("idle_after_done_busy", {31'd0, busy}, 32'd0);
            check("idle_after_done_valid", {31'd0, byte_valid}, 32'd0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        slot_base   = 5'd0;
        slot_stride = 5'd0;
        fill_bank();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_rd_slot", {27'd0, rd_slot}, 32'd0);
        check("rst_rd_addr", {24'd0, rd_addr}, 32'd0);
        check("rst_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_data", {24'd0, byte_data}, 32'd0);
        rst_n = 1'b1;

        // slots 0,3,6, coeff[i]=i in slot 0, ready held high
        push3(8'h00, 8'h10, 8'h00);
        push3(8'h02, 8'h30, 8'h00);
        push_model(5'd0, 5'd3, 2);
        run(5'd0, 5'd3, 1 << 30, 1'b0, 1'b0);

        // same stream under random backpressure
        rand_ready = 1'b1;
        push_model(5'd0, 5'd3, 0);
        run(5'd0, 5'd3, 1 << 30, 1'b0, 1'b0);

        // start pulses while busy, reset at byte 500, then a fresh full run
        push_model(5'd0, 5'd3, 0);
        run(5'd0, 5'd3, 500, 1'b0, 1'b1);
        push_model(5'd0, 5'd3, 0);
        run(5'd0, 5'd3, 1 << 30, 1'b1, 1'b1);

        // hand-packed pairs: ABC/123, FFF/000, D01/D01
        rand_ready = 1'b0;
        bank[0][0] = 12'hABC;
        bank[0][1] = 12'h123;
        bank[0][2] = 12'hFFF;
        bank[0][3] = 12'h000;
        bank[0][4] = 12'd3329;
        bank[0][5] = 12'd3329;
        push3(8'hBC, 8'h3A, 8'h12);
`ifdef POLY_ENC_REDUCE_EN
        push3(8'hFE, 8'h02, 8'h00);
        push3(8'h00, 8'h00, 8'h00);
`else
        push3(8'hFF, 8'h0F, 8'h00);
        push3(8'h01, 8'h1D, 8'hD0);
`endif
        push_model(5'd0, 5'd3, 3);
        run(5'd0, 5'd3, 1 << 30, 1'b0, 1'b0);

        // 5-bit slot wrap
        push_model(5'd30, 5'd3, 0);
        run(5'd30, 5'd3, 1 << 30, 1'b0, 1'b0);
        check("slot_count", slot_q.size(), 32'd3);
        if (slot_q.size() == 3) begin
            check("slot0", {27'd0, slot_q[0]}, 32'd30);
            check("slot1", {27'd0, slot_q[1]}, 32'd1);
            check("slot2", {27'd0, slot_q[2]}, 32'd4);
        end

        check("total_done", done_count, 32'd5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
